dm_be_ctrl: RTL
===============

Name: dm_be_ctrl

Overview:
- Parametrised single-port data memory controller for the pipelined MIPS core, MEM stage.
- Accepts byte, half and word loads and stores through a valid/ready request and a one-cycle-latency response.
- Generates byte enables internally, sign- or zero-extends load data, and flags misaligned or out-of-range accesses.
- Clears the whole array with a sequential clear engine after reset or on command.

Parameters:
- DEPTH_LOG2, 11, log2 of word count; the array holds 2**DEPTH_LOG2 32-bit words.
- LOG_EN, 1, when 1 every committed store prints "*%h <= %h" (byte address, stored bits of the access width) via $display.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- clr_start  in  1  one-cycle request to re-clear the array; honoured only in READY.
- busy  out  1  high while the clear engine runs.
- req_valid  in  1  access request present.
- req_ready  out  1  request accepted this cycle when valid && ready; combinational.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 illegal; [2]: 1 = zero-extend (lbu/lhu), ignored for stores and word ops.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse, exactly one per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  accepted request was misaligned, out of range or illegal; qualified by rsp_valid.

Behaviour:
- Reset (reset==0 at an edge):
  - state <= CLEAR, clear pointer <= 0.
  - rsp_valid, rsp_err <= 0; rsp_rdata <= 0.
  - busy reads 1 from the first edge after reset asserts.
  - A reset mid-clear restarts the pointer at 0. A reset with a request pending discards it and produces no response.
- States:
  - CLEAR: each cycle writes 0 to word[ptr] and increments ptr. At ptr == 2**DEPTH_LOG2-1, that word is written and the next state is READY.
    - Clear takes exactly 2**DEPTH_LOG2 cycles after reset deasserts.
    - busy=1 and req_ready=0 throughout CLEAR.
  - READY: busy=0; req_ready = !clr_start.
    - clr_start=1 moves to CLEAR with ptr <= 0. It takes priority over a simultaneous req_valid, which is not accepted.
- Address decode:
  - word index = req_addr[DEPTH_LOG2+1:2]; lane = req_addr[1:0].
  - Error if any of the following holds:
    - req_addr[31:DEPTH_LOG2+2] != 0;
    - half access with addr[0]=1;
    - word access with addr[1:0] != 0;
    - req_op[1:0] == 11.
  - An errored access makes no array write. Its response is rsp_err=1, rdata=0.
- Stores, committed at the acceptance edge:
  - byte: enable = 1<<lane; wdata[7:0] goes to bits [8*lane+7 : 8*lane].
  - half: enable 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata[15:0] goes to the selected half.
  - word: all four lanes are written.
  - Unselected bytes are unchanged.
- Loads: the word is read at the acceptance edge. On the next cycle:
  - byte: the lane is selected and extended from bit 7.
  - half: the half is selected and extended from bit 15.
  - word: passed through.
  - Extension is sign unless req_op[2]=1.
- Latency and throughput:
  - rsp_valid is high on the cycle after acceptance and low otherwise.
  - One request per cycle is sustained back-to-back.
  - A load accepted the cycle after a store to the same word returns the updated data.
- Clear while a response is pending: a request accepted in the cycle before clr_start still gets its response on the next cycle. Its data is the pre-clear value.

Test Plan:
- Reset low 2 cycles with DEPTH_LOG2=4, then release -> busy=1 for exactly 16 cycles, then req_ready=1. A load of word 15 returns 0 with rsp_err=0.
- sw 0x00000004 data 0x11223344, then sb addr 0x00000006 data 0xAB -> lw 0x4 returns 0x11AB3344. lb 0x6 returns 0xFFFFFFAB; lbu 0x6 returns 0x000000AB.
- sh 0x00000008 data 0x8001 with addr[1]=0 -> lh 0x8 returns 0xFFFF8001, lhu returns 0x00008001. sh 0x0A data 0x7F00 then lw 0x8 returns 0x7F008001.
- lh 0x5, sw 0x2, and lw at 0x40 (DEPTH_LOG2=4) -> each gives rsp_valid with rsp_err=1 and rdata=0; memory contents unchanged.
- sw 0x0 data 0xDEADBEEF, then lw 0x0 on the next cycle back-to-back -> response returns 0xDEADBEEF with rsp_valid high on 2 consecutive cycles.
- clr_start together with req_valid (lw 0x0) -> request not accepted, busy=1 for 16 cycles; the subsequent lw 0x0 returns 0. Pulse reset at clear cycle 5 -> busy stays 1 for a full 16 cycles after release.

Source files
------------

// File: rtl/dm_be_ctrl.sv
// dm_be_ctrl: data memory controller for the MEM stage of the pipelined MIPS core.
// Handles byte, half and word loads and stores. Byte enables are built internally
// and load data is sign- or zero-extended. Accesses that are misaligned, out of
// range or use an illegal size are flagged. After reset, or on clr_start, a clear
// engine walks the array and zeroes every word.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   clr_start, busy clear request (READY only) / clear engine running
//   req_*           valid/ready access request (we, op, byte address, right-aligned wdata)
//   rsp_*           one-cycle response pulse with extended load data and error flag
module dm_be_ctrl #(
  parameter int DEPTH_LOG2 = 11,
  parameter bit LOG_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_start,
  output logic        busy,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORDS = 2 ** DEPTH_LOG2;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [31:0]           mem [WORDS];

  // Registered response context, used to extend the load data one cycle later.
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;
  logic [1:0]  rsp_size_q, rsp_size_d;
  logic        rsp_zext_q, rsp_zext_d;
  logic [1:0]  rsp_lane_q, rsp_lane_d;
  logic [31:0] rd_word_q, rd_word_d;

  // Address decode.
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic [1:0]            size;
  logic                  err;
  logic [3:0]            be;
  logic [31:0]           wdata_rep;
  logic                  accept;
  logic                  st_commit;

  always_comb begin
    idx  = req_addr[DEPTH_LOG2+1:2];
    lane = req_addr[1:0];
    size = req_op[1:0];
    err  = (|(req_addr >> (DEPTH_LOG2 + 2))) ||
           (size == 2'b01 && req_addr[0]) ||
           (size == 2'b10 && req_addr[1:0] != 2'b00) ||
           (size == 2'b11);
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (size)
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    accept    = req_valid && req_ready;
    st_commit = accept && req_we && !err;
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_READY;
      end
      default: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // FSM: outputs. Holding reset low keeps ready low, so no request is taken
  // (and no store committed) on a reset edge.
  always_comb begin
    busy      = (state_q == ST_CLEAR);
    req_ready = (state_q == ST_READY) && !clr_start && reset;
  end

  // Array write port: the clear engine and stores are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == ST_CLEAR) begin
        mem[ptr_q] <= '0;
      end else if (st_commit) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Response capture. The read happens at the acceptance edge, so a store
  // committed on the previous edge is already visible.
  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && err;
    rsp_load_d  = accept && !req_we && !err;
    rsp_size_d  = size;
    rsp_zext_d  = req_op[2];
    rsp_lane_d  = lane;
    rd_word_d   = rd_word_q;
    if (accept && !req_we && !err) rd_word_d = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_size_q  <= 2'b00;
      rsp_zext_q  <= 1'b0;
      rsp_lane_q  <= 2'b00;
      rd_word_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      rsp_size_q  <= rsp_size_d;
      rsp_zext_q  <= rsp_zext_d;
      rsp_lane_q  <= rsp_lane_d;
      rd_word_q   <= rd_word_d;
    end
  end

  // Lane select and extension; stores and errors return zero.
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = 8'h00;
    case (rsp_lane_q)
      2'd0:    rbyte = rd_word_q[7:0];
      2'd1:    rbyte = rd_word_q[15:8];
      2'd2:    rbyte = rd_word_q[23:16];
      default: rbyte = rd_word_q[31:24];
    endcase
    rhalf     = rsp_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    rsp_rdata = '0;
    if (rsp_valid_q && rsp_load_q) begin
      case (rsp_size_q)
        2'b00:   rsp_rdata = {{24{rbyte[7] & ~rsp_zext_q}}, rbyte};
        2'b01:   rsp_rdata = {{16{rhalf[15] & ~rsp_zext_q}}, rhalf};
        default: rsp_rdata = rd_word_q;
      endcase
    end
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_valid_q && rsp_err_q;
  end

  // Store trace: byte address and the stored bits of the access width.
`ifndef SYNTHESIS
  generate
    if (LOG_EN) begin : g_log
      always_ff @(posedge clk) begin
        if (reset && st_commit) begin
          case (size)
            2'b00:   $display("*%h <= %h", req_addr, req_wdata[7:0]);
            2'b01:   $display("*%h <= %h", req_addr, req_wdata[15:0]);
            default: $display("*%h <= %h", req_addr, req_wdata);
          endcase
        end
      end
    end
  endgenerate
`endif

endmodule
